mem_rd_gearbox: RTL and testbench

Parametrised read-path gearbox for the SDRAM controller ports. It runs in the SDRAM clock domain and assembles narrow memory read beats (MEM_DW) into wide bus words (WB_DW) by address lane. Completed words are buffered in a FIFO with real downstream backpressure. Beats that cannot be stored, and beats that would mix two word addresses, are reported on sticky error flags instead of being silently lost. It replaces the fixed 16->32 read upsizer, whose output was always-ready and whose ready output was unconnected.

---
 rtl/mem_if_pkg.sv | 33 +++
 rtl/mem_rd_gearbox_if.sv | 31 +++
 rtl/mem_fifo_fwft.sv | 56 +++++
 rtl/mem_rd_gearbox.sv | 114 +++++++++++
 tb/tb_mem_rd_gearbox.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared helpers for the SDRAM port gearboxes: width ratios, lane-index widths
// and parameter sanity checks common to the read and write paths.
package mem_if_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int ratio_of(input int wide_dw, input int narrow_dw);
    return wide_dw / narrow_dw;
  endfunction

  function automatic int lb_of(input int wide_dw, input int narrow_dw);
    return clog2(wide_dw / narrow_dw);
  endfunction

  // Legal configuration: integral power-of-2 ratio, room for at least one
  // word-address bit, power-of-2 FIFO depth of at least 2.
  function automatic bit rd_cfg_ok(input int wide_dw, input int narrow_dw,
                                   input int aw, input int depth);
    return (narrow_dw > 0) && (wide_dw % narrow_dw == 0) &&
           is_pow2(wide_dw / narrow_dw) && (aw >= lb_of(wide_dw, narrow_dw) + 1) &&
           is_pow2(depth) && (depth >= 2);
  endfunction

endpackage

// File: rtl/mem_rd_gearbox_if.sv
// Beat-in / word-out bus of the read gearbox, including flush and sticky error flags.
interface mem_rd_gearbox_if #(
  parameter int WB_DW  = 32,
  parameter int MEM_DW = 16,
  parameter int AW     = 5
);
  localparam int LB = mem_if_pkg::lb_of(WB_DW, MEM_DW);

  logic [AW-1:0]    s_adr_i;
  logic [MEM_DW-1:0] s_data_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [AW-LB-1:0] m_adr_o;
  logic [WB_DW-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic             flush_i;
  logic             err_clr_i;
  logic             ovf_o;
  logic             mis_o;

  modport slave (
    input  s_adr_i, s_data_i, s_valid_i, m_ready_i, flush_i, err_clr_i,
    output s_ready_o, m_adr_o, m_data_o, m_valid_o, ovf_o, mis_o
  );

  modport master (
    output s_adr_i, s_data_i, s_valid_i, m_ready_i, flush_i, err_clr_i,
    input  s_ready_o, m_adr_o, m_data_o, m_valid_o, ovf_o, mis_o
  );
endinterface

// File: rtl/mem_fifo_fwft.sv
// First-word-fall-through FIFO: head data is visible whenever valid_o is high,
// and reads as zero while empty.
module mem_fifo_fwft
  import mem_if_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [clog2(DEPTH):0]  count_o,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       head_o
);
  localparam int PW = clog2(DEPTH);

  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      count_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != (PW+1)'(DEPTH)) && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  // NOTE: sequential state is updated only with <= so every always_ff reads the
  // pre-edge value of every register, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; only pointers and count are reset,
  // and the head is masked to zero while empty so stale contents never show.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem[rd_q] : '0;
endmodule

// File: rtl/mem_rd_gearbox.sv
// Read-path gearbox: assembles MEM_DW beats into WB_DW words by address lane and
// queues completed words in a FWFT FIFO with real backpressure and sticky errors.
module mem_rd_gearbox
  import mem_if_pkg::*;
#(
  parameter int WB_DW  = 32,
  parameter int MEM_DW = 16,
  parameter int AW     = 5,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_rd_gearbox_if.slave  bus
);
  localparam int RATIO = ratio_of(WB_DW, MEM_DW);
  localparam int LB    = lb_of(WB_DW, MEM_DW);
  localparam int LW    = (LB == 0) ? 1 : LB;
  localparam int WAW   = AW - LB;
  localparam int CW    = clog2(DEPTH) + 1;
  localparam int FW    = WB_DW + WAW;

  if (!rd_cfg_ok(WB_DW, MEM_DW, AW, DEPTH)) begin : g_cfg_err
    $error("mem_rd_gearbox: illegal WB_DW/MEM_DW/AW/DEPTH combination");
  end

  logic [WB_DW-1:0] asm_data_q, asm_data_d, next_data;
  logic [RATIO-1:0] asm_mask_q, asm_mask_d, next_mask;
  logic [WAW-1:0]   asm_adr_q, asm_adr_d, word;
  logic [LW-1:0]    lane;
  logic             ovf_q, ovf_d, mis_q, mis_d;
  logic             accept, push, pop, ovf_set, mis_set;
  logic [CW-1:0]    fifo_count;
  logic             fifo_valid;
  logic [FW-1:0]    fifo_head;

  assign bus.s_ready_o = (fifo_count < CW'(DEPTH));
  assign accept        = bus.s_valid_i && bus.s_ready_o && !bus.flush_i;
  assign ovf_set       = bus.s_valid_i && !bus.s_ready_o;
  assign lane          = LW'(bus.s_adr_i & AW'(RATIO - 1));
  assign word          = WAW'(bus.s_adr_i >> LB);
  assign pop           = fifo_valid && bus.m_ready_i;

  // NOTE: every variable assigned here gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    asm_data_d = asm_data_q;
    asm_mask_d = asm_mask_q;
    asm_adr_d  = asm_adr_q;
    next_data  = asm_data_q;
    next_mask  = asm_mask_q;
    push       = 1'b0;
    mis_set    = 1'b0;
    if (accept) begin
      // A beat for another word abandons the partial one and restarts assembly.
      if ((asm_mask_q != '0) && (word != asm_adr_q)) begin
        mis_set   = 1'b1;
        next_mask = '0;
      end
      next_mask = next_mask | (RATIO'(1) << lane);
      for (int k = 0; k < RATIO; k++) begin
        if (LW'(k) == lane) next_data[k*MEM_DW +: MEM_DW] = bus.s_data_i;
      end
      asm_data_d = next_data;
      asm_adr_d  = word;
      if (&next_mask) begin
        push       = 1'b1;
        asm_mask_d = '0;
      end else begin
        asm_mask_d = next_mask;
      end
    end
    if (bus.flush_i) asm_mask_d = '0;
  end

  // A same-cycle set wins over the clear.
  assign ovf_d = (ovf_q && !bus.err_clr_i) || ovf_set;
  assign mis_d = (mis_q && !bus.err_clr_i) || mis_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data_q <= '0;
      asm_mask_q <= '0;
      asm_adr_q  <= '0;
      ovf_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      asm_data_q <= asm_data_d;
      asm_mask_q <= asm_mask_d;
      asm_adr_q  <= asm_adr_d;
      ovf_q      <= ovf_d;
      mis_q      <= mis_d;
    end
  end

  mem_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({word, next_data}),
    .pop_i   (pop),
    .flush_i (bus.flush_i),
    .count_o (fifo_count),
    .valid_o (fifo_valid),
    .head_o  (fifo_head)
  );

  assign bus.m_valid_o = fifo_valid;
  assign {bus.m_adr_o, bus.m_data_o} = fifo_head;
  assign bus.ovf_o = ovf_q;
  assign bus.mis_o = mis_q;
endmodule

// File: tb/tb_mem_rd_gearbox.sv
// Bench for mem_rd_gearbox: a 32/16 depth-4 instance (a) and a 16/16 depth-2
// instance (b), both compared every cycle against a lane/queue reference model.
module tb_mem_rd_gearbox;
  typedef struct packed {
    logic [4:0]  adr;
    logic [31:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_rd_gearbox_if #(.WB_DW(32), .MEM_DW(16), .AW(5)) ifa ();
  mem_rd_gearbox_if #(.WB_DW(16), .MEM_DW(16), .AW(5)) ifb ();

  mem_rd_gearbox #(.WB_DW(32), .MEM_DW(16), .AW(5), .DEPTH(4)) u_a (
    .clk (clk), .rst (rst_a), .bus (ifa));
  mem_rd_gearbox #(.WB_DW(16), .MEM_DW(16), .AW(5), .DEPTH(2)) u_b (
    .clk (clk), .rst (rst_b), .bus (ifb));

  // Reference model: per-instance lane buffers and a queue of expected words.
  word_t       exp_q [2][$];
  logic [15:0] lane_d [2][2];
  bit          lane_m [2][2];
  logic [4:0]  asm_adr [2];
  bit          m_ovf [2];
  bit          m_mis [2];

  function automatic int ratio_of(int id);
    return (id == 0) ? 2 : 1;
  endfunction

  function automatic int depth_of(int id);
    return (id == 0) ? 4 : 2;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(int id);
    exp_q[id].delete();
    lane_m[id][0] = 1'b0;
    lane_m[id][1] = 1'b0;
    m_ovf[id] = 1'b0;
    m_mis[id] = 1'b0;
  endtask

  task automatic model_step(int id, logic [4:0] adr, logic [15:0] d, logic v,
                            logic rdy, logic fl, logic clr);
    int    r;
    bit    ready, valid, ovf_set, mis_set, any;
    int    w, l;
    word_t e;
    r       = ratio_of(id);
    ready   = exp_q[id].size() < depth_of(id);
    valid   = exp_q[id].size() != 0;
    ovf_set = v && !ready;
    mis_set = 1'b0;
    if (fl) begin
      lane_m[id][0] = 1'b0;
      lane_m[id][1] = 1'b0;
      exp_q[id].delete();
    end else begin
      if (valid && rdy) void'(exp_q[id].pop_front());
      if (v && ready) begin
        w   = int'(adr) / r;
        l   = int'(adr) % r;
        any = lane_m[id][0] || lane_m[id][1];
        if (any && (5'(w) != asm_adr[id])) begin
          mis_set = 1'b1;
          lane_m[id][0] = 1'b0;
          lane_m[id][1] = 1'b0;
        end
        lane_d[id][l] = d;
        lane_m[id][l] = 1'b1;
        asm_adr[id]   = 5'(w);
        if (lane_m[id][0] && (r == 1 || lane_m[id][1])) begin
          e.adr  = 5'(w);
          e.data = (r == 2) ? {lane_d[id][1], lane_d[id][0]} : {16'h0, lane_d[id][0]};
          exp_q[id].push_back(e);
          lane_m[id][0] = 1'b0;
          lane_m[id][1] = 1'b0;
        end
      end
    end
    if (clr) begin
      m_ovf[id] = 1'b0;
      m_mis[id] = 1'b0;
    end
    if (ovf_set) m_ovf[id] = 1'b1;
    if (mis_set) m_mis[id] = 1'b1;
  endtask

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) model_reset(0);
    else model_step(0, ifa.s_adr_i, ifa.s_data_i, ifa.s_valid_i, ifa.m_ready_i,
                    ifa.flush_i, ifa.err_clr_i);
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) model_reset(1);
    else model_step(1, ifb.s_adr_i, ifb.s_data_i, ifb.s_valid_i, ifb.m_ready_i,
                    ifb.flush_i, ifb.err_clr_i);
  end

  task automatic compare(int id, logic rdy, logic val, logic [4:0] adr,
                         logic [31:0] data, logic ovf, logic mis);
    bit ev;
    ev = exp_q[id].size() != 0;
    check($sformatf("dut%0d.s_ready", id), rdy, exp_q[id].size() < depth_of(id));
    check($sformatf("dut%0d.m_valid", id), val, ev);
    check($sformatf("dut%0d.ovf", id), ovf, m_ovf[id]);
    check($sformatf("dut%0d.mis", id), mis, m_mis[id]);
    if (ev) begin
      check($sformatf("dut%0d.m_data", id), data, exp_q[id][0].data);
      check($sformatf("dut%0d.m_adr", id), adr, exp_q[id][0].adr);
    end
  endtask

  always @(negedge clk) begin
    compare(0, ifa.s_ready_o, ifa.m_valid_o, {1'b0, ifa.m_adr_o}, ifa.m_data_o,
            ifa.ovf_o, ifa.mis_o);
    compare(1, ifb.s_ready_o, ifb.m_valid_o, ifb.m_adr_o, {16'h0, ifb.m_data_o},
            ifb.ovf_o, ifb.mis_o);
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat_a(logic [4:0] adr, logic [15:0] d);
    ifa.s_adr_i   = adr;
    ifa.s_data_i  = d;
    ifa.s_valid_i = 1'b1;
    tick();
    ifa.s_valid_i = 1'b0;
  endtask

  task automatic beat_b(logic [4:0] adr, logic [15:0] d);
    ifb.s_adr_i   = adr;
    ifb.s_data_i  = d;
    ifb.s_valid_i = 1'b1;
    tick();
    ifb.s_valid_i = 1'b0;
  endtask

  task automatic check_reset_b(string tag);
    check({tag, ".s_ready"}, ifb.s_ready_o, 1'b1);
    check({tag, ".m_valid"}, ifb.m_valid_o, 1'b0);
    check({tag, ".m_data"}, ifb.m_data_o, 16'h0);
    check({tag, ".m_adr"}, ifb.m_adr_o, 5'h0);
    check({tag, ".ovf"}, ifb.ovf_o, 1'b0);
    check({tag, ".mis"}, ifb.mis_o, 1'b0);
  endtask

  initial begin
    {ifa.s_adr_i, ifa.s_data_i, ifa.s_valid_i, ifa.m_ready_i, ifa.flush_i, ifa.err_clr_i} = '0;
    {ifb.s_adr_i, ifb.s_data_i, ifb.s_valid_i, ifb.m_ready_i, ifb.flush_i, ifb.err_clr_i} = '0;
    #12;
    check("rst_a.s_ready", ifa.s_ready_o, 1'b1);
    check("rst_a.m_valid", ifa.m_valid_o, 1'b0);
    check("rst_a.m_data", ifa.m_data_o, 32'h0);
    check("rst_a.m_adr", ifa.m_adr_o, 4'h0);
    check("rst_a.ovf", ifa.ovf_o, 1'b0);
    check("rst_a.mis", ifa.mis_o, 1'b0);
    #10;
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // In-order pair, then a wrapped pair.
    ifa.m_ready_i = 1'b1;
    beat_a(5'h04, 16'hBEEF);
    beat_a(5'h05, 16'hDEAD);
    check("pair.m_valid", ifa.m_valid_o, 1'b1);
    check("pair.m_data", ifa.m_data_o, 32'hDEADBEEF);
    check("pair.m_adr", ifa.m_adr_o, 4'h2);
    tick();
    check("pair.one_cycle", ifa.m_valid_o, 1'b0);
    beat_a(5'h07, 16'h1111);
    beat_a(5'h06, 16'h2222);
    check("wrap.m_data", ifa.m_data_o, 32'h11112222);
    check("wrap.m_adr", ifa.m_adr_o, 4'h3);
    check("wrap.mis", ifa.mis_o, 1'b0);
    tick();

    // Address mismatch drops the partial at word 4.
    beat_a(5'h08, 16'hAAAA);
    beat_a(5'h0B, 16'hBBBB);
    beat_a(5'h0A, 16'hCCCC);
    check("mis.flag", ifa.mis_o, 1'b1);
    check("mis.m_data", ifa.m_data_o, 32'hBBBBCCCC);
    check("mis.m_adr", ifa.m_adr_o, 4'h5);
    tick();
    check("mis.no_partial", ifa.m_valid_o, 1'b0);
    ifa.err_clr_i = 1'b1;
    tick();
    ifa.err_clr_i = 1'b0;
    check("mis.clear", ifa.mis_o, 1'b0);

    // Backpressure: five words offered, four fit, the fifth overflows.
    ifa.m_ready_i = 1'b0;
    for (int w = 0; w < 5; w++) begin
      beat_a(5'(2 * w), 16'hA000 | 16'(w));
      beat_a(5'(2 * w + 1), 16'hB000 | 16'(w));
    end
    check("bp.s_ready", ifa.s_ready_o, 1'b0);
    check("bp.ovf", ifa.ovf_o, 1'b1);
    ifa.m_ready_i = 1'b1;
    for (int w = 0; w < 4; w++) begin
      check($sformatf("bp.drain%0d.valid", w), ifa.m_valid_o, 1'b1);
      check($sformatf("bp.drain%0d.data", w), ifa.m_data_o,
            32'hB000A000 | (32'(w) << 16) | 32'(w));
      check($sformatf("bp.drain%0d.adr", w), ifa.m_adr_o, 4'(w));
      tick();
    end
    check("bp.empty", ifa.m_valid_o, 1'b0);
    ifa.err_clr_i = 1'b1;
    tick();
    ifa.err_clr_i = 1'b0;
    check("bp.ovf_clear", ifa.ovf_o, 1'b0);

    // Flush with two words queued and a partial pending.
    ifa.m_ready_i = 1'b0;
    beat_a(5'h10, 16'h1010);
    beat_a(5'h11, 16'h1111);
    beat_a(5'h12, 16'h1212);
    beat_a(5'h13, 16'h1313);
    beat_a(5'h14, 16'h1414);
    ifa.flush_i = 1'b1;
    tick();
    ifa.flush_i = 1'b0;
    check("flush.m_valid", ifa.m_valid_o, 1'b0);
    check("flush.s_ready", ifa.s_ready_o, 1'b1);
    ifa.m_ready_i = 1'b1;
    beat_a(5'h00, 16'h0001);
    beat_a(5'h01, 16'h0002);
    check("flush.next_data", ifa.m_data_o, 32'h00020001);
    check("flush.next_adr", ifa.m_adr_o, 4'h0);
    tick();

    // Randomised traffic on instance a, mostly sequential addresses.
    begin
      logic [4:0] seq;
      seq = '0;
      for (int i = 0; i < 3000; i++) begin
        ifa.s_valid_i = ($urandom_range(3) != 0);
        if ($urandom_range(15) == 0) ifa.s_adr_i = 5'($urandom);
        else begin
          ifa.s_adr_i = seq;
          if (ifa.s_valid_i) seq = seq + 5'd1;
        end
        ifa.s_data_i  = 16'($urandom);
        ifa.m_ready_i = ($urandom_range(2) != 0);
        ifa.flush_i   = ($urandom_range(63) == 0);
        ifa.err_clr_i = ($urandom_range(31) == 0);
        tick();
      end
      ifa.s_valid_i = 1'b0;
      ifa.flush_i   = 1'b0;
      ifa.err_clr_i = 1'b0;
      ifa.m_ready_i = 1'b1;
      tick(6);
    end

    // Instance b (RATIO=1, DEPTH=2): fill, overflow, then pop with a completing beat.
    ifb.m_ready_i = 1'b0;
    beat_b(5'h01, 16'h0101);
    beat_b(5'h02, 16'h0202);
    beat_b(5'h03, 16'h0303);
    check("b.full.s_ready", ifb.s_ready_o, 1'b0);
    check("b.full.ovf", ifb.ovf_o, 1'b1);
    ifb.err_clr_i = 1'b1;
    tick();
    ifb.err_clr_i = 1'b0;
    check("b.ovf_clear", ifb.ovf_o, 1'b0);
    ifb.m_ready_i = 1'b1;
    beat_b(5'h07, 16'h0707);
    check("b.popfull.ovf", ifb.ovf_o, 1'b1);
    check("b.popfull.s_ready", ifb.s_ready_o, 1'b1);
    check("b.popfull.m_data", ifb.m_data_o, 16'h0202);
    check("b.popfull.m_adr", ifb.m_adr_o, 5'h02);

    // Asynchronous reset mid-stream.
    ifb.s_adr_i   = 5'h04;
    ifb.s_data_i  = 16'h0404;
    ifb.s_valid_i = 1'b1;
    tick();
    #2;
    rst_b = 1'b1;
    #1;
    check_reset_b("b.rst_async");
    tick();
    check_reset_b("b.rst_held");
    #2;
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ifb.s_adr_i  = 5'(8 + i);
      ifb.s_data_i = 16'h5A00 | 16'(i);
      tick();
      check($sformatf("b.stream%0d.valid", i), ifb.m_valid_o, 1'b1);
      check($sformatf("b.stream%0d.data", i), ifb.m_data_o, 16'h5A00 | 16'(i));
      check($sformatf("b.stream%0d.adr", i), ifb.m_adr_o, 5'(8 + i));
    end
    ifb.s_valid_i = 1'b0;
    tick(2);

    // Randomised traffic on instance b.
    for (int i = 0; i < 1500; i++) begin
      ifb.s_valid_i = ($urandom_range(3) != 0);
      ifb.s_adr_i   = 5'($urandom);
      ifb.s_data_i  = 16'($urandom);
      ifb.m_ready_i = ($urandom_range(2) != 0);
      ifb.flush_i   = ($urandom_range(63) == 0);
      ifb.err_clr_i = ($urandom_range(31) == 0);
      tick();
    end
    ifb.s_valid_i = 1'b0;
    ifb.flush_i   = 1'b0;
    ifb.err_clr_i = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
